// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, opcode[6:2]
// major-opcode constants (also used by the decoder) and fault codes.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_e;

  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] OP     = 5'b01100;
  localparam logic [4:0] JAL    = 5'b11011;
  localparam logic [4:0] BRANCH = 5'b11000;
  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] STORE  = 5'b01000;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_IMEM_TO = 2'b10;
  localparam logic [1:0] FC_DMEM_TO = 2'b11;

  function automatic logic opcode_legal(input logic [6:0] op);
    logic [4:0] f;
    f = op[6:2];
    return (op[1:0] == 2'b11) &&
           (f == OP_IMM || f == OP || f == JAL || f == BRANCH || f == LOAD || f == STORE);
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op[6:2] == LOAD) || (op[6:2] == STORE);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> core/memory signal bundle; master is the sequencer side.
interface multicycle_sequencer_if #(parameter int unsigned CNT_W = 32);
  logic [6:0]       opcode;
  logic             dec_reg_write;
  logic             dec_branch;
  logic             dec_wb_pc;
  logic             br_taken;
  logic             halt;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_we;
  logic             pc_we;
  logic             pc_sel;
  logic             rf_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             fault;
  logic [1:0]       fault_code;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, dec_reg_write, dec_branch, dec_wb_pc, br_taken, halt,
           imem_ready, dmem_ready,
    output imem_req, ir_we, pc_we, pc_sel, rf_we, dmem_req, dmem_we,
           fault, fault_code, halted, retired
  );

  modport slave (
    output opcode, dec_reg_write, dec_branch, dec_wb_pc, br_taken, halt,
           imem_ready, dmem_ready,
    input  imem_req, ir_we, pc_we, pc_sel, rf_we, dmem_req, dmem_we,
           fault, fault_code, halted, retired
  );
endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Saturating wait counter shared by FETCH and MEM; timeout flags once the
// count has reached MEM_TIMEOUT (the caller lets a same-cycle ready win).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic timeout
);
  localparam int unsigned RAW_W = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned W     = (RAW_W < 4) ? 4 : RAW_W;
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  // Any cycle without a pending wait clears the count.
  always_comb begin
    cnt_d = '0;
    if (en) cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == LIMIT);
endmodule

// File: rtl/multicycle_sequencer.sv
// One-instruction-at-a-time FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// timeouts, sticky fault reporting and a retired-instruction counter.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst_n,
  multicycle_sequencer_if.master bus
);
  state_e           state_q, state_d;
  logic [1:0]       fc_q, fc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             wait_en, timeout;
  logic             imem_req, ir_we, pc_we, pc_sel, rf_we, dmem_req, dmem_we, fault, halted;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (wait_en),
    .timeout (timeout)
  );

  always_comb begin
    state_d  = state_q;
    fc_d     = fc_q;
    ret_d    = ret_q;
    wait_en  = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    fault    = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = bus.halt ? S_HALT : S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_en = 1'b1;
          if (timeout) begin
            state_d = S_FAULT;
            fc_d    = FC_IMEM_TO;
          end
        end
      end
      S_DECODE: begin
        if (opcode_legal(bus.opcode)) state_d = S_EXEC;
        else begin
          state_d = S_FAULT;
          fc_d    = FC_ILLEGAL;
        end
      end
      S_EXEC: state_d = is_mem_op(bus.opcode) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (bus.opcode[6:2] == STORE);
        if (bus.dmem_ready) state_d = S_WB;
        else begin
          wait_en = 1'b1;
          if (timeout) begin
            state_d = S_FAULT;
            fc_d    = FC_DMEM_TO;
          end
        end
      end
      S_WB: begin
        // Loads always write rd even if the decoder flag is clear.
        rf_we   = bus.dec_reg_write | (bus.opcode[6:2] == LOAD);
        pc_we   = 1'b1;
        pc_sel  = bus.dec_wb_pc | (bus.dec_branch & bus.br_taken);
        ret_d   = ret_q + 1'b1;
        state_d = bus.halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!bus.halt) state_d = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fc_q    <= FC_NONE;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.pc_sel     = pc_sel;
  assign bus.rf_we      = rf_we;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.fault      = fault;
  assign bus.fault_code = fc_q;
  assign bus.halted     = halted;
  assign bus.retired    = ret_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed vector bench for multicycle_sequencer: table of instructions plus
// hand sequences for halt, counter wrap, faults and reset.
module tb_multicycle_sequencer;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   n_ret = 0;

  multicycle_sequencer_if #(.CNT_W(CW)) bus ();

  multicycle_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    bit rw, br, wbpc, bt;
    int iw, dw;
    bit halt_exec;
    int e_cyc, e_rf, e_pcsel, e_dreq, e_dwe;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_sel, bus.rf_we, bus.dmem_req,
                    bus.dmem_we, bus.fault, bus.fault_code, bus.halted, bus.retired}), 0);
  endtask

  task automatic run_instr(input vec_t v, output int cyc, output int n_ir, output int n_pc,
                           output int n_rf, output int n_dreq, output int pcsel,
                           output int dwe, output int done);
    int fk = 0;
    int dk = 0;
    int t = 0;
    bit started = 0;
    cyc = 0; n_ir = 0; n_pc = 0; n_rf = 0; n_dreq = 0; pcsel = 0; dwe = 0; done = 0;
    while (t < 80 && done == 0) begin
      t++;
      @(negedge clk);
      bus.opcode        = v.op;
      bus.dec_reg_write = v.rw;
      bus.dec_branch    = v.br;
      bus.dec_wb_pc     = v.wbpc;
      bus.br_taken      = v.bt;
      if (v.halt_exec && started && cyc == 2) bus.halt = 1'b1;
      bus.imem_ready = bus.imem_req && (fk == v.iw);
      bus.dmem_ready = bus.dmem_req && (dk == v.dw);
      #1;
      if (bus.imem_req) started = 1;
      if (started) cyc++;
      if (bus.imem_req) fk++;
      if (bus.dmem_req) begin
        dk++;
        n_dreq++;
        if (bus.dmem_we) dwe = 1;
      end
      n_ir += int'(bus.ir_we);
      n_pc += int'(bus.pc_we);
      n_rf += int'(bus.rf_we);
      if (bus.pc_we) begin
        pcsel = int'(bus.pc_sel);
        done  = 1;
      end
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.halt = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero(name);
    rst_n = 1'b1;
    n_ret = 0;
  endtask

  task automatic run_fault(input string name, input logic [6:0] op, input bit imem_ok,
                           input bit dmem_ok, input int exp_code, input int exp_req);
    int t = 0;
    int seen = 0;
    int n_req = 0;
    int n_strb = 0;
    while (t < 60 && seen == 0) begin
      t++;
      @(negedge clk);
      bus.opcode = op;
      bus.dec_reg_write = 1'b1;
      bus.imem_ready = imem_ok && bus.imem_req;
      bus.dmem_ready = dmem_ok && bus.dmem_req;
      #1;
      if (bus.fault) seen = 1;
      else begin
        n_req  += int'(bus.imem_req) + int'(bus.dmem_req);
        n_strb += int'(bus.rf_we) + int'(bus.pc_we);
      end
    end
    chk({name, "_seen"}, seen, 1);
    chk({name, "_code"}, int'(bus.fault_code), exp_code);
    chk({name, "_reqcyc"}, n_req, exp_req);
    chk({name, "_nostrobe"}, n_strb, 0);
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk({name, "_quiet"}, int'({bus.imem_req, bus.dmem_req, bus.ir_we, bus.pc_we, bus.rf_we}), 0);
      chk({name, "_sticky"}, int'({bus.fault, bus.fault_code}), 4 | exp_code);
    end
    do_reset({name, "_reset"});
  endtask

  initial begin
    int cyc, n_ir, n_pc, n_rf, n_dreq, pcsel, dwe, done;

    //           op     rw br wb bt iw dw h  cyc rf sel dreq dwe
    vecs[0] = '{7'h13, 1, 0, 0, 0, 0, 0, 0, 4,  1, 0, 0,  0};
    vecs[1] = '{7'h63, 0, 1, 0, 1, 0, 0, 0, 4,  0, 1, 0,  0};
    vecs[2] = '{7'h63, 0, 1, 0, 0, 0, 0, 0, 4,  0, 0, 0,  0};
    vecs[3] = '{7'h03, 0, 0, 0, 0, 0, 2, 0, 7,  1, 0, 3,  0};
    vecs[4] = '{7'h23, 0, 0, 0, 0, 2, 0, 0, 7,  0, 0, 1,  1};
    vecs[5] = '{7'h6F, 1, 0, 1, 0, 0, 0, 0, 4,  1, 1, 0,  0};
    vecs[6] = '{7'h33, 1, 0, 0, 1, 15, 0, 0, 19, 1, 0, 0,  0};
    vecs[7] = '{7'h03, 1, 0, 0, 0, 0, 15, 0, 20, 1, 0, 16, 0};
    vecs[8] = '{7'h33, 0, 0, 0, 0, 3, 0, 0, 7,  0, 0, 0,  0};
    vecs[9] = '{7'h13, 1, 0, 0, 0, 0, 0, 1, 4,  1, 0, 0,  0};

    rst_n = 1'b0;
    bus.opcode = '0; bus.dec_reg_write = 0; bus.dec_branch = 0; bus.dec_wb_pc = 0;
    bus.br_taken = 0; bus.halt = 0; bus.imem_ready = 0; bus.dmem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_init");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i], cyc, n_ir, n_pc, n_rf, n_dreq, pcsel, dwe, done);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_cyc", i), cyc, vecs[i].e_cyc);
      chk($sformatf("v%0d_ir_we", i), n_ir, 1);
      chk($sformatf("v%0d_pc_we", i), n_pc, 1);
      chk($sformatf("v%0d_rf_we", i), n_rf, vecs[i].e_rf);
      chk($sformatf("v%0d_pc_sel", i), pcsel, vecs[i].e_pcsel);
      chk($sformatf("v%0d_dmem_req", i), n_dreq, vecs[i].e_dreq);
      chk($sformatf("v%0d_dmem_we", i), dwe, vecs[i].e_dwe);
      @(posedge clk);
      #1;
      n_ret = (n_ret + 1) % 16;
      chk($sformatf("v%0d_retired", i), int'(bus.retired), n_ret);
      if (vecs[i].halt_exec) begin
        chk("halt_enter", int'({bus.halted, bus.imem_req}), 2);
        repeat (2) begin
          @(posedge clk);
          #1;
          chk("halt_hold", int'({bus.halted, bus.imem_req, bus.pc_we}), 4);
        end
        bus.halt = 1'b0;
        @(posedge clk);
        #1;
        chk("halt_resume", int'({bus.halted, bus.imem_req}), 1);
      end
    end

    // Six more instructions take the 4-bit counter from 10 through 15 to 0.
    for (int i = 0; i < 6; i++) begin
      run_instr(vecs[0], cyc, n_ir, n_pc, n_rf, n_dreq, pcsel, dwe, done);
      chk($sformatf("wrap%0d_done", i), done, 1);
      @(posedge clk);
      #1;
      n_ret = (n_ret + 1) % 16;
      chk($sformatf("wrap%0d_retired", i), int'(bus.retired), n_ret);
    end
    chk("wrap_zero", int'(bus.retired), 0);

    run_fault("illegal_7f", 7'h7F, 1, 1, 1, 1);
    run_fault("illegal_lowbits", 7'h10, 1, 1, 1, 1);
    run_fault("imem_timeout", 7'h13, 0, 1, 2, 16);
    run_fault("dmem_timeout", 7'h03, 1, 0, 3, 17);

    // After reset the sequencer must run a normal instruction again.
    run_instr(vecs[0], cyc, n_ir, n_pc, n_rf, n_dreq, pcsel, dwe, done);
    chk("post_reset_done", done, 1);
    chk("post_reset_cyc", cyc, 4);
    @(posedge clk);
    #1;
    chk("post_reset_retired", int'(bus.retired), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
